regfile_dump_reader: RTL and testbench

Debug/scan-out engine for the Tiny RV1 register file.
- On a start pulse, walks a contiguous register range through the regfile's single read port.
- Streams each register's value, with its index, out on a val/rdy interface.
- Sits beside the processor datapath and feeds the debug/host link; it is the consumer (reader) of the 1r1w regfile.

---
 rtl/regfile_dump_reader.sv | 126 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - streams a regfile range out as addr/value beats
// Optional XOR checksum beat at the end of the dump: define REGFILE_DUMP_CSUM_EN.
module regfile_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_data,
    output logic [4:0]  out_addr,
    output logic        out_last,
    output logic        out_csum
);
    localparam logic [4:0] FIRST = FIRST_REG[4:0];
    localparam logic [4:0] LAST  = LAST_REG[4:0];

    typedef enum logic [2:0] {IDLE, FETCH, SEND, FIN, CSUM} state_t;

    state_t      state;
    logic [4:0]  count;
`ifdef REGFILE_DUMP_CSUM_EN
    logic [31:0] acc;
    logic        csum_q;

    assign out_csum = csum_q;
`else
    assign out_csum = 1'b0;
`endif

    // rf_raddr is loaded one cycle ahead so it equals count throughout FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_val  <= 1'b0;
            out_last <= 1'b0;
            out_data <= 32'd0;
            out_addr <= 5'd0;
            rf_raddr <= 5'd0;
            count    <= FIRST;
`ifdef REGFILE_DUMP_CSUM_EN
            acc      <= 32'd0;
            csum_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= FIRST;
                        rf_raddr <= FIRST;
                        busy     <= 1'b1;
                        state    <= FETCH;
`ifdef REGFILE_DUMP_CSUM_EN
                        acc      <= 32'd0;
`endif
                    end
                end
                FETCH: begin
                    out_data <= rf_rdata;
                    out_addr <= count;
                    out_val  <= 1'b1;
                    state    <= SEND;
`ifdef REGFILE_DUMP_CSUM_EN
                    out_last <= 1'b0;
                    csum_q   <= 1'b0;
`else
                    out_last <= (count == LAST);
`endif
                end
                SEND: begin
                    if (out_rdy) begin
                        out_val <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
                        if (csum_q) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            acc <= acc ^ out_data;
                            if (count == LAST) begin
                                state <= CSUM;
                            end else begin
                                count    <= count + 5'd1;
                                rf_raddr <= count + 5'd1;
                                state    <= FETCH;
                            end
                        end
`else
                        if (count == LAST) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            count    <= count + 5'd1;
                            rf_raddr <= count + 5'd1;
                            state    <= FETCH;
                        end
`endif
                    end
                end
`ifdef REGFILE_DUMP_CSUM_EN
                CSUM: begin
                    out_data <= acc;
                    out_addr <= 5'd0;
                    out_last <= 1'b1;
                    csum_q   <= 1'b1;
                    out_val  <= 1'b1;
                    state    <= SEND;
                end
`endif
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - random-stimulus bench for regfile_dump_reader
module tb_regfile_dump_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] regs [32];
    int          sel;
    logic        start_d, rdy;

    logic        busy0, done0, val0, last0, csum0;
    logic [4:0]  raddr0, addr0;
    logic [31:0] data0, rdata0;
    logic        busy1, done1, val1, last1, csum1;
    logic [4:0]  raddr1, addr1;
    logic [31:0] data1, rdata1;

    assign rdata0 = regs[raddr0];
    assign rdata1 = regs[raddr1];

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u_full (
        .clk(clk), .rst_n(rst_n), .start(start_d && sel == 0), .busy(busy0), .done(done0),
        .rf_raddr(raddr0), .rf_rdata(rdata0), .out_val(val0), .out_rdy(rdy && sel == 0),
        .out_data(data0), .out_addr(addr0), .out_last(last0), .out_csum(csum0));

    regfile_dump_reader #(.FIRST_REG(3), .LAST_REG(5)) u_sub (
        .clk(clk), .rst_n(rst_n), .start(start_d && sel == 1), .busy(busy1), .done(done1),
        .rf_raddr(raddr1), .rf_rdata(rdata1), .out_val(val1), .out_rdy(rdy && sel == 1),
        .out_data(data1), .out_addr(addr1), .out_last(last1), .out_csum(csum1));

    logic        m_busy, m_done, m_val, m_last, m_csum;
    logic [4:0]  m_addr, m_raddr;
    logic [31:0] m_data;
    always_comb begin
        m_busy  = sel == 1 ? busy1  : busy0;
        m_done  = sel == 1 ? done1  : done0;
        m_val   = sel == 1 ? val1   : val0;
        m_last  = sel == 1 ? last1  : last0;
        m_csum  = sel == 1 ? csum1  : csum0;
        m_addr  = sel == 1 ? addr1  : addr0;
        m_raddr = sel == 1 ? raddr1 : raddr0;
        m_data  = sel == 1 ? data1  : data0;
    end

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        logic        csum;
    } beat_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_regs(input bit ramp);
        for (int i = 0; i < 32; i++)
            regs[i] <= (i == 0) ? 32'd0 : (ramp ? 32'h100 + 32'(i) : $urandom);
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high; 1: four stall cycles per beat; 2: random ready.
    task automatic run_dump(input int s, input int mode, input bit wr7, input bit dbl);
        beat_t       q[$];
        beat_t       b;
        int          first, last, k, cyc, stall, wr_cd;
        bit          expect_done, fin, prev_stall;
        logic [31:0] pd;
        logic [4:0]  pa;
        logic        pl;
`ifdef REGFILE_DUMP_CSUM_EN
        logic [31:0] x = 32'd0;
`endif
        first = s == 1 ? 3 : 0;
        last  = s == 1 ? 5 : 31;
        for (int i = first; i <= last; i++) begin
            b.addr = 5'(i);
            b.data = regs[i];
            b.csum = 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
            b.last = 1'b0;
            x ^= b.data;
`else
            b.last = (i == last);
`endif
            q.push_back(b);
        end
`ifdef REGFILE_DUMP_CSUM_EN
        b.addr = 5'd0; b.data = x; b.last = 1'b1; b.csum = 1'b1;
        q.push_back(b);
`endif
        sel = s;
        start_d = 1'b1;
        @(posedge clk);
        #1;
        start_d = 1'b0;
        k = 0; cyc = 0; stall = 0; wr_cd = 0;
        expect_done = 1'b0; fin = 1'b0; prev_stall = 1'b0;
        pd = '0; pa = '0; pl = 1'b0;
        while (!fin && cyc < 3000) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (stall >= 4);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            start_d = dbl && (cyc == 3 || expect_done);
            @(negedge clk);
            if (cyc == 0) begin
                chk("fetch_busy", 32'(m_busy), 32'd1);
                chk("fetch_val", 32'(m_val), 32'd0);
            end
            if (cyc == 1) chk("first_val_latency", 32'(m_val), 32'd1);
            chk("done", 32'(m_done), 32'(expect_done));
            if (expect_done) begin
                chk("fin_busy", 32'(m_busy), 32'd1);
                if (mode == 0) chk("throughput", 32'(cyc), 32'(2 * q.size()));
                fin = 1'b1;
            end else if (prev_stall) begin
                chk("hold_val", 32'(m_val), 32'd1);
                chk("hold_data", m_data, pd);
                chk("hold_addr", 32'(m_addr), 32'(pa));
                chk("hold_last", 32'(m_last), 32'(pl));
            end
            prev_stall = m_val && !rdy;
            pd = m_data; pa = m_addr; pl = m_last;
            if (prev_stall) stall++;
            if (m_val && rdy && !expect_done) begin
                if (k < q.size()) begin
                    chk("beat_addr", 32'(m_addr), 32'(q[k].addr));
                    chk("beat_data", m_data, q[k].data);
                    chk("beat_last", 32'(m_last), 32'(q[k].last));
                    chk("beat_csum", 32'(m_csum), 32'(q[k].csum));
                end else begin
                    chk("extra_beat", 32'd1, 32'd0);
                end
                if (wr7 && m_addr == 5'd6 && !m_csum) wr_cd = 2;
                k++;
                stall = 0;
                if (k == q.size()) expect_done = 1'b1;
            end
            @(posedge clk);
            if (wr_cd == 1) regs[7] <= 32'hDEAD;
            if (wr_cd > 0) wr_cd--;
            #1;
            cyc++;
        end
        if (!fin) chk("timeout", 32'(cyc), 32'd0);
        chk("beat_count", 32'(k), 32'(q.size()));
        start_d = 1'b0;
        rdy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_val", 32'(m_val), 32'd0);
            chk("idle_done", 32'(m_done), 32'd0);
            chk("idle_busy", 32'(m_busy), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 0; start_d = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_val", 32'(val0), 32'd0);
        chk("rst_data", data0, 32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_raddr", 32'(raddr0), 32'd0);
        chk("rst_last", 32'(last0), 32'd0);
        chk("rst_csum", 32'(csum0), 32'd0);
        @(posedge clk);
        #1;

        load_regs(1'b1);
        run_dump(0, 0, 1'b1, 1'b0);
        run_dump(1, 1, 1'b0, 1'b0);
        run_dump(1, 2, 1'b0, 1'b1);
        run_dump(0, 2, 1'b0, 1'b1);

        load_regs(1'b0);
        sel = 0;
        start_d = 1'b1;
        @(posedge clk);
        #1;
        start_d = 1'b0;
        for (int i = 0; i < 4 && !m_val; i++) @(negedge clk);
        chk("rst_mid_send_val", 32'(m_val), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(m_busy), 32'd0);
        chk("abort_val", 32'(m_val), 32'd0);
        chk("abort_done", 32'(m_done), 32'd0);
        chk("abort_data", m_data, 32'd0);
        rdy = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("abort_no_beat", 32'(m_val), 32'd0);
            chk("abort_no_done", 32'(m_done), 32'd0);
        end
        rdy = 1'b0;
        @(posedge clk);
        #1;

        repeat (6) begin
            load_regs(1'b0);
            run_dump(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
